user_img_mem: RTL and testbench

- Parametrised, writable image buffer in the user domain; successor to the fixed-size read-only image ROM.
- Holds an ImgWidth x ImgHeight frame of PixelWidth-bit pixels.
- One OBI subordinate port provides CPU read/write access.
- NumAccel accelerator read channels address pixels by signed (x,y) coordinates, with configurable border handling.
- Single-ported storage is shared by round-robin arbitration among the accelerator channels; OBI always takes priority.

---
 rtl/user_img_mem.sv | 256 +++++++++++++++++++++++++
 tb/tb_user_img_mem.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_img_mem.sv
// -----------------------------------------------------------------------------
// user_img_mem
//   Writable ImgWidth x ImgHeight image buffer of PixelWidth-bit pixels.
//   An OBI subordinate gives the CPU read/write access: one pixel per 32-bit
//   word, addr[1:0] ignored. NumAccel accelerator read channels address pixels
//   by signed (x,y) coordinates. Out-of-frame reads return zero
//   (BorderMode=0) or the nearest edge pixel (BorderMode=1). The
//   single-ported store is shared. OBI always wins. The accelerator channels
//   are served round-robin.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   obi_req_i/rsp_o   OBI subordinate (gnt = req, response one cycle later)
//   accel_req_i       per-channel read request (hold until granted)
//   accel_gnt_o       per-channel grant (combinational)
//   accel_x_i/y_i     per-channel signed column / row
//   accel_rvalid_o    per-channel read data valid (one cycle after grant)
//   accel_rdata_o     per-channel read data (held between reads)
// -----------------------------------------------------------------------------
package user_img_mem_pkg;

  typedef struct packed {
    int unsigned addr_width;
    int unsigned data_width;
    int unsigned id_width;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{addr_width: 32'd32, data_width: 32'd32, id_width: 32'd1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

module user_img_mem #(
  parameter user_img_mem_pkg::obi_cfg_t ObiCfg = user_img_mem_pkg::ObiDefaultConfig,
  parameter type obi_req_t = user_img_mem_pkg::obi_req_t,
  parameter type obi_rsp_t = user_img_mem_pkg::obi_rsp_t,
  parameter int unsigned ImgWidth   = 16,
  parameter int unsigned ImgHeight  = 16,
  parameter int unsigned PixelWidth = 8,
  parameter int unsigned NumAccel   = 2,
  parameter int unsigned BorderMode = 0,
  parameter int unsigned CoordWidth = $clog2((ImgWidth > ImgHeight) ? ImgWidth : ImgHeight) + 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  obi_req_t                             obi_req_i,
  output obi_rsp_t                             obi_rsp_o,
  input  logic [NumAccel-1:0]                  accel_req_i,
  output logic [NumAccel-1:0]                  accel_gnt_o,
  input  logic [NumAccel-1:0][CoordWidth-1:0]  accel_x_i,
  input  logic [NumAccel-1:0][CoordWidth-1:0]  accel_y_i,
  output logic [NumAccel-1:0]                  accel_rvalid_o,
  output logic [NumAccel-1:0][PixelWidth-1:0]  accel_rdata_o
);

  localparam int unsigned Depth     = ImgWidth * ImgHeight;
  localparam int unsigned IdxWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned RrWidth   = (NumAccel > 1) ? $clog2(NumAccel) : 1;
  localparam int unsigned AddrWidth = ObiCfg.addr_width;
  localparam int unsigned DataWidth = ObiCfg.data_width;
  localparam int unsigned IdWidth   = ObiCfg.id_width;
  localparam logic [AddrWidth-3:0] DepthWords = (AddrWidth-2)'(Depth);

  typedef logic [Depth-1:0][PixelWidth-1:0] mem_t;

  // Power-on / reset image: pixel[i] = i mod 16.
  function automatic mem_t init_pattern();
    mem_t m;
    for (int unsigned i = 32'd0; i < Depth; i++) begin
      m[i] = PixelWidth'(i % 32'd16);
    end
    return m;
  endfunction

  localparam mem_t InitPattern = init_pattern();

  // Clamp a signed coordinate into [0, dim-1].
  function automatic int clamp_coord(input int v, input int dim);
    int r;
    if (v < 32'sd0) begin
      r = 32'sd0;
    end else if (v >= dim) begin
      r = dim - 32'sd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  mem_t                               mem_r;
  logic [AddrWidth-3:0]               obi_word_s;
  logic [IdxWidth-1:0]                obi_idx_s;
  logic                               obi_oob_s;
  logic                               obi_wr_s;
  logic                               obi_rvalid_r;
  logic [IdWidth-1:0]                 obi_rid_r;
  logic                               obi_err_r;
  logic [DataWidth-1:0]               obi_rdata_r;
  logic [NumAccel-1:0]                gnt_s;
  logic                               grant_any_s;
  logic [RrWidth-1:0]                 sel_s;
  logic [RrWidth-1:0]                 rr_r;
  logic [RrWidth-1:0]                 rr_next_s;
  int unsigned                        cand_s;
  int                                 acc_x_s;
  int                                 acc_y_s;
  logic                               acc_out_s;
  logic [IdxWidth-1:0]                acc_idx_s;
  logic [PixelWidth-1:0]              acc_pix_s;
  logic [NumAccel-1:0]                accel_rvalid_r;
  logic [NumAccel-1:0][PixelWidth-1:0] accel_rdata_r;
  logic                               unused_s;

  // addr[1:0], upper wdata bits, be[3:1] and a_optional carry no meaning here.
  assign unused_s = ^{obi_req_i.a.addr, obi_req_i.a.be, obi_req_i.a.wdata, obi_req_i.a.a_optional};

  assign obi_word_s = obi_req_i.a.addr[AddrWidth-1:2];
  assign obi_idx_s  = obi_word_s[IdxWidth-1:0];
  assign obi_oob_s  = (obi_word_s >= DepthWords);
  assign obi_wr_s   = obi_req_i.req & obi_req_i.a.we & obi_req_i.a.be[0] & ~obi_oob_s;

  // Round-robin pick starting at rr_r; any OBI request blocks all channels.
  always_comb begin
    gnt_s       = '0;
    grant_any_s = 1'b0;
    sel_s       = '0;
    cand_s      = 32'd0;
    if (!obi_req_i.req) begin
      for (int unsigned i = 32'd0; i < NumAccel; i++) begin
        cand_s = 32'(rr_r) + i;
        cand_s = (cand_s >= NumAccel) ? (cand_s - NumAccel) : cand_s;
        if (accel_req_i[RrWidth'(cand_s)] && !grant_any_s) begin
          grant_any_s = 1'b1;
          sel_s       = RrWidth'(cand_s);
        end else begin
          grant_any_s = grant_any_s;
        end
      end
      if (grant_any_s) begin
        gnt_s[sel_s] = 1'b1;
      end else begin
        gnt_s = '0;
      end
    end else begin
      gnt_s = '0;
    end
  end

  // Pointer moves to the channel after the one just served.
  always_comb begin
    if ((32'(sel_s) + 32'd1) >= NumAccel) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = sel_s + RrWidth'(1);
    end
  end

  // Border handling for the granted channel's coordinate.
  always_comb begin
    acc_x_s   = int'($signed(accel_x_i[sel_s]));
    acc_y_s   = int'($signed(accel_y_i[sel_s]));
    acc_out_s = (acc_x_s < 32'sd0) || (acc_x_s >= int'(ImgWidth)) ||
                (acc_y_s < 32'sd0) || (acc_y_s >= int'(ImgHeight));
    // Always index with clamped coordinates so the array is never read out of range.
    acc_idx_s = IdxWidth'(clamp_coord(acc_y_s, int'(ImgHeight)) * int'(ImgWidth) +
                          clamp_coord(acc_x_s, int'(ImgWidth)));
    if (acc_out_s && (BorderMode == 32'd0)) begin
      acc_pix_s = '0;
    end else begin
      acc_pix_s = mem_r[acc_idx_s];
    end
  end

  // Pixel storage: reset reloads the test pattern, OBI writes land on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_r <= InitPattern;
    end else if (obi_wr_s) begin
      mem_r[obi_idx_s] <= obi_req_i.a.wdata[PixelWidth-1:0];
    end
  end

  // OBI response register: every request is answered the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      obi_rvalid_r <= 1'b0;
      obi_rid_r    <= '0;
      obi_err_r    <= 1'b0;
      obi_rdata_r  <= '0;
    end else begin
      obi_rvalid_r <= obi_req_i.req;
      if (obi_req_i.req) begin
        obi_rid_r   <= obi_req_i.a.aid;
        obi_err_r   <= obi_oob_s;
        obi_rdata_r <= (!obi_req_i.a.we && !obi_oob_s) ? DataWidth'(mem_r[obi_idx_s]) : '0;
      end
    end
  end

  // Accelerator responses and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_r           <= '0;
      accel_rvalid_r <= '0;
      accel_rdata_r  <= '0;
    end else begin
      accel_rvalid_r <= gnt_s;
      if (grant_any_s) begin
        rr_r                 <= rr_next_s;
        accel_rdata_r[sel_s] <= acc_pix_s;
      end
    end
  end

  // Response struct assembly.
  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = obi_req_i.req;
    obi_rsp_o.rvalid       = obi_rvalid_r;
    obi_rsp_o.r.rdata      = obi_rdata_r;
    obi_rsp_o.r.rid        = obi_rid_r;
    obi_rsp_o.r.err        = obi_err_r;
    obi_rsp_o.r.r_optional = 1'b0;
  end

  assign accel_gnt_o    = gnt_s;
  assign accel_rvalid_o = accel_rvalid_r;
  assign accel_rdata_o  = accel_rdata_r;

endmodule

// File: tb/tb_user_img_mem.sv
// Scoreboard bench: two instances (BorderMode 0 and 1) share all stimulus.
// The driver runs a reference model each cycle and queues expected grants
// and responses. Monitors pop and compare when the DUTs present outputs.
module tb_user_img_mem;
  import user_img_mem_pkg::*;

  localparam int NA = 2, CW = 6, PW = 8, W = 16, H = 16, DEPTH = 256;

  typedef struct {
    int          b;      // instance
    int          k;      // channel, -1 for OBI
    int          due;    // cycle at which rvalid must be seen
    logic [31:0] data;
    logic        rid;
    logic        err;
  } exp_t;

  typedef struct {
    logic          og;
    logic [NA-1:0] ag;
  } gexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  obi_req_t obi_req;
  obi_rsp_t rsp [2];
  logic [NA-1:0]         areq;
  logic [NA-1:0][CW-1:0] ax, ay;
  logic [NA-1:0]         gnt [2];
  logic [NA-1:0]         rv  [2];
  logic [NA-1:0][PW-1:0] rd  [2];

  user_img_mem #(.BorderMode(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(obi_req), .obi_rsp_o(rsp[0]),
    .accel_req_i(areq), .accel_gnt_o(gnt[0]), .accel_x_i(ax), .accel_y_i(ay),
    .accel_rvalid_o(rv[0]), .accel_rdata_o(rd[0]));

  user_img_mem #(.BorderMode(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(obi_req), .obi_rsp_o(rsp[1]),
    .accel_req_i(areq), .accel_gnt_o(gnt[1]), .accel_x_i(ax), .accel_y_i(ay),
    .accel_rvalid_o(rv[1]), .accel_rdata_o(rd[1]));

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  int          model_mem [DEPTH];
  int          rr_m;
  logic [PW-1:0] last_m [2][NA];
  exp_t  exp_q [$];
  gexp_t gnt_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = i % 16;
    rr_m = 0;
    exp_q.delete();
    for (int b = 0; b < 2; b++) for (int k = 0; k < NA; k++) last_m[b][k] = '0;
  endfunction

  function automatic int pix(input int b, input int x, input int y);
    bit out;
    int xc, yc;
    out = (x < 0) || (x >= W) || (y < 0) || (y >= H);
    if (out && b == 0) return 0;
    xc = (x < 0) ? 0 : ((x >= W) ? W - 1 : x);
    yc = (y < 0) ? 0 : ((y >= H) ? H - 1 : y);
    return model_mem[yc * W + xc];
  endfunction

  function automatic int find(input int b, input int k);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].b == b && exp_q[i].k == k) return i;
    return -1;
  endfunction

  // One bus cycle: apply inputs at the falling edge, model the cycle, queue expectations.
  task automatic cyc(input logic oreq, input logic [31:0] addr, input logic we,
                     input logic [3:0] be, input logic [31:0] wd, input logic aid,
                     input logic [NA-1:0] rq, input logic [NA-1:0][CW-1:0] xs,
                     input logic [NA-1:0][CW-1:0] ys, input bit kill, output int granted);
    gexp_t g;
    exp_t e;
    int idx;
    obi_req = '0;
    obi_req.req = oreq; obi_req.a.addr = addr; obi_req.a.we = we;
    obi_req.a.be = be; obi_req.a.wdata = wd; obi_req.a.aid = aid;
    areq = rq; ax = xs; ay = ys;
    #1;
    granted = -1;
    if (!oreq)
      for (int i = 0; i < NA; i++) begin
        int c;
        c = (rr_m + i) % NA;
        if (rq[c]) begin granted = c; break; end
      end
    g.og = oreq;
    g.ag = '0;
    if (granted >= 0) g.ag[granted] = 1'b1;
    gnt_q.push_back(g);
    if (!kill) begin
      if (oreq) begin
        idx = int'(addr >> 2);
        for (int b = 0; b < 2; b++) begin
          e.b = b; e.k = -1; e.due = cyc_n + 1; e.rid = aid;
          e.err = (idx >= DEPTH);
          e.data = (!we && idx < DEPTH) ? 32'(model_mem[idx]) : 32'd0;
          exp_q.push_back(e);
        end
        if (we && be[0] && idx < DEPTH) model_mem[idx] = int'(wd[PW-1:0]);
      end else if (granted >= 0) begin
        for (int b = 0; b < 2; b++) begin
          e.b = b; e.k = granted; e.due = cyc_n + 1; e.rid = 1'b0; e.err = 1'b0;
          e.data = 32'(pix(b, int'($signed(xs[granted])), int'($signed(ys[granted]))));
          exp_q.push_back(e);
        end
        rr_m = (granted + 1) % NA;
      end
    end else begin
      #1 rst = 1'b1;
      model_reset();
    end
    @(negedge clk);
  endtask

  function automatic logic [NA-1:0][CW-1:0] co(input int c0, input int c1);
    logic [NA-1:0][CW-1:0] r;
    r[0] = CW'(c0);
    r[1] = CW'(c1);
    return r;
  endfunction

  task automatic obi(input logic [31:0] addr, input logic we, input logic [3:0] be,
                     input logic [31:0] wd);
    int gk;
    cyc(1'b1, addr, we, be, wd, addr[2], '0, '0, '0, 1'b0, gk);
  endtask

  task automatic acc(input logic [NA-1:0] rq, input int x0, input int y0,
                     input int x1, input int y1);
    int gk;
    cyc(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, rq, co(x0, x1), co(y0, y1), 1'b0, gk);
  endtask

  task automatic do_reset();
    obi_req = '0; areq = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Grant monitor: grants are combinational, sampled mid low-phase.
  always @(negedge clk) begin
    gexp_t g;
    #3;
    if (gnt_q.size() > 0) begin
      g = gnt_q.pop_front();
      for (int b = 0; b < 2; b++) begin
        chk("obi_gnt", 64'(rsp[b].gnt), 64'(g.og));
        chk("accel_gnt", 64'(gnt[b]), 64'(g.ag));
      end
    end
  end

  // Response monitor: pops an expectation whenever a DUT presents rvalid.
  always @(posedge clk) begin
    int i;
    #1;
    for (int b = 0; b < 2; b++) begin
      if (rsp[b].rvalid) begin
        i = find(b, -1);
        if (i < 0) chk("obi_unexpected_rvalid", 64'd1, 64'd0);
        else begin
          chk("obi_latency", 64'(cyc_n), 64'(exp_q[i].due));
          chk("obi_rdata", 64'(rsp[b].r.rdata), 64'(exp_q[i].data));
          chk("obi_err", 64'(rsp[b].r.err), 64'(exp_q[i].err));
          chk("obi_rid", 64'(rsp[b].r.rid), 64'(exp_q[i].rid));
          exp_q.delete(i);
        end
      end
      for (int k = 0; k < NA; k++) begin
        if (rv[b][k]) begin
          i = find(b, k);
          if (i < 0) chk("accel_unexpected_rvalid", 64'd1, 64'd0);
          else begin
            chk("accel_latency", 64'(cyc_n), 64'(exp_q[i].due));
            chk("accel_rdata", 64'(rd[b][k]), 64'(exp_q[i].data));
            last_m[b][k] = exp_q[i].data[PW-1:0];
            exp_q.delete(i);
          end
        end else begin
          chk("accel_rdata_hold", 64'(rd[b][k]), 64'(last_m[b][k]));
        end
      end
    end
    // Anything due by now and not yet seen is a missing response.
    for (int j = exp_q.size() - 1; j >= 0; j--)
      if (exp_q[j].due <= cyc_n) begin
        chk("missing_rvalid", 64'd0, 64'd1);
        exp_q.delete(j);
      end
  end

  initial begin
    int gk;
    logic [NA-1:0] pend;
    int px [NA];
    int py [NA];
    logic [31:0] addr;

    obi_req = '0; areq = '0; ax = '0; ay = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      chk("reset_rvalid", 64'(rsp[b].rvalid), 64'd0);
      chk("reset_rdata", 64'(rsp[b].r.rdata), 64'd0);
      chk("reset_err", 64'(rsp[b].r.err), 64'd0);
      chk("reset_rid", 64'(rsp[b].r.rid), 64'd0);
      chk("reset_accel_rvalid", 64'(rv[b]), 64'd0);
    end
    rst = 1'b0;

    // OBI basics, byte-enable, out-of-range
    obi(32'h0, 1'b0, 4'h0, 32'h0);
    obi(32'h44, 1'b0, 4'h0, 32'h0);
    obi(32'h40, 1'b1, 4'hF, 32'hABCD12A5);
    obi(32'h40, 1'b0, 4'h0, 32'h0);
    obi(32'h40, 1'b1, 4'h0, 32'h00000011);
    obi(32'h40, 1'b0, 4'h0, 32'h0);
    obi(32'h400, 1'b0, 4'h0, 32'h0);
    obi(32'h400, 1'b1, 4'hF, 32'h000000FF);
    obi(32'h0, 1'b0, 4'h0, 32'h0);
    obi(32'h3FD, 1'b0, 4'h0, 32'h0);

    // Both channels streaming, one OBI request in the middle
    acc(2'b11, 1, 0, 2, 0);
    acc(2'b11, 1, 0, 2, 0);
    cyc(1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 1'b1, 2'b11, co(1, 2), co(0, 0), 1'b0, gk);
    acc(2'b11, 1, 0, 2, 0);
    acc(2'b11, 1, 0, 2, 0);
    acc(2'b11, 1, 0, 2, 0);
    acc(2'b00, 0, 0, 0, 0);

    // Border handling (dut0 zero, dut1 clamp)
    acc(2'b01, -1, 3, 0, 0);
    acc(2'b01, 20, 20, 0, 0);
    acc(2'b01, 3, -2, 0, 0);
    acc(2'b01, 16, 2, 0, 0);
    acc(2'b10, 0, 0, -5, 7);

    // Reset restores the pattern and the arbitration pointer
    obi(32'h10, 1'b1, 4'h1, 32'h00000077);
    obi(32'h10, 1'b0, 4'h0, 32'h0);
    do_reset();
    obi(32'h10, 1'b0, 4'h0, 32'h0);
    acc(2'b01, 5, 0, 0, 0);
    cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 2'b01, co(6, 0), co(0, 0), 1'b1, gk);
    rst = 1'b0;
    acc(2'b11, 4, 0, 7, 0);
    acc(2'b00, 0, 0, 0, 0);

    // Randomized traffic; pending accelerator requests hold their coordinates
    pend = '0;
    for (int k = 0; k < NA; k++) begin px[k] = 0; py[k] = 0; end
    for (int n = 0; n < 400; n++) begin
      logic [NA-1:0][CW-1:0] xs, ys;
      logic oreq;
      for (int k = 0; k < NA; k++) begin
        if (!pend[k] && $urandom_range(99, 0) < 50) begin
          pend[k] = 1'b1;
          px[k] = int'($urandom_range(23, 0)) - 4;
          py[k] = int'($urandom_range(23, 0)) - 4;
        end else if (pend[k] && $urandom_range(99, 0) < 5) begin
          pend[k] = 1'b0;
        end
        xs[k] = CW'(px[k]);
        ys[k] = CW'(py[k]);
      end
      oreq = ($urandom_range(99, 0) < 25);
      if ($urandom_range(99, 0) < 85) addr = {22'd0, 8'($urandom_range(255, 0)), 2'($urandom_range(3, 0))};
      else addr = 32'($urandom_range(300, 256)) << 2;
      cyc(oreq, addr, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), $urandom,
          1'($urandom_range(1, 0)), pend, xs, ys, 1'b0, gk);
      if (gk >= 0) pend[gk] = 1'b0;
    end

    acc(2'b00, 0, 0, 0, 0);
    acc(2'b00, 0, 0, 0, 0);
    acc(2'b00, 0, 0, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
